// File: rtl/store_drain_ctrl.sv
// Store-buffer drain controller: arbitrates the single data-memory port between
// loads and store-buffer drains, and sequences each drain as issue, ack, then pop.
module store_drain_ctrl #(
  parameter int unsigned ENTRY_COUNT  = 4,
  parameter int unsigned HIGH_WATER   = 3,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = $clog2(ENTRY_COUNT + 1)
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              sb_deq_valid_i,
  input  logic [31:0]       sb_deq_addr_i,
  input  logic [31:0]       sb_deq_data_i,
  input  logic [CNT_W-1:0]  sb_count_i,
  input  logic              sb_flush_i,
  output logic              sb_deq_req_o,
  input  logic              ld_req_valid_i,
  input  logic [31:0]       ld_req_addr_i,
  output logic              ld_req_ready_o,
  output logic              ld_resp_valid_o,
  output logic [31:0]       ld_resp_data_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_we_o,
  output logic [31:0]       mem_req_addr_o,
  output logic [31:0]       mem_req_wdata_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_resp_valid_i,
  input  logic [31:0]       mem_resp_rdata_i,
  input  logic              drain_all_i,
  output logic              drain_done_o,
  output logic              busy_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    LD_ISSUE = 3'd3,
    LD_WAIT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                drain_mode_q, drain_mode_d;
  logic                abandon_q, abandon_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                store_go;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      drain_mode_q <= 1'b0;
      abandon_q    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      drain_mode_q <= drain_mode_d;
      abandon_q    <= abandon_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  // Store wins in IDLE when forced by fence, high water or starvation, or when no load competes.
  assign store_go = sb_deq_valid_i &&
                    (drain_mode_q ||
                     (sb_count_i >= CNT_W'(HIGH_WATER)) ||
                     (starve_q >= STARVE_W'(STARVE_LIMIT)) ||
                     !ld_req_valid_i);

  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    abandon_d       = abandon_q;
    addr_d          = addr_q;
    data_d          = data_q;
    sb_deq_req_o    = 1'b0;
    ld_req_ready_o  = 1'b0;
    ld_resp_valid_o = 1'b0;
    ld_resp_data_o  = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    busy_o          = (state_q != IDLE);
    drain_done_o    = drain_mode_q && (state_q == IDLE) && !sb_deq_valid_i;
    drain_mode_d    = drain_mode_q ? !drain_done_o : drain_all_i;

    case (state_q)
      IDLE: begin
        if (store_go) begin
          addr_d   = sb_deq_addr_i;
          data_d   = sb_deq_data_i;
          starve_d = '0;
          state_d  = ST_ISSUE;
        end else if (ld_req_valid_i && !drain_mode_q) begin
          // Ready is masked by reset so every output reads 0 while reset is held.
          ld_req_ready_o = reset_ni;
          addr_d         = ld_req_addr_i;
          data_d         = '0;
          state_d        = LD_ISSUE;
          if (sb_deq_valid_i && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = addr_q;
        mem_req_wdata_o = data_q;
        if (sb_flush_i) abandon_d = 1'b1;
        if (mem_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sb_flush_i) abandon_d = 1'b1;
        // Pop only after the write ack so forwarding from the buffer stays valid until then.
        if (mem_resp_valid_i) begin
          sb_deq_req_o = !(abandon_q || sb_flush_i);
          abandon_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      LD_ISSUE: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = addr_q;
        if (mem_req_ready_i) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem_resp_valid_i) begin
          ld_resp_valid_o = 1'b1;
          ld_resp_data_o  = mem_resp_rdata_i;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl: one task per scenario, inline comparisons.
module tb_store_drain_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        sb_deq_valid_i = 1'b0;
  logic [31:0] sb_deq_addr_i = '0;
  logic [31:0] sb_deq_data_i = '0;
  logic [2:0]  sb_count_i = '0;
  logic        sb_flush_i = 1'b0;
  logic        sb_deq_req_o;
  logic        ld_req_valid_i = 1'b0;
  logic [31:0] ld_req_addr_i = '0;
  logic        ld_req_ready_o;
  logic        ld_resp_valid_o;
  logic [31:0] ld_resp_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_resp_rdata_i = '0;
  logic        drain_all_i = 1'b0;
  logic        drain_done_o;
  logic        busy_o;

  int checks = 0;
  int passes = 0;

  store_drain_ctrl dut (
    .clock_i(clock_i), .reset_ni(reset_ni),
    .sb_deq_valid_i(sb_deq_valid_i), .sb_deq_addr_i(sb_deq_addr_i),
    .sb_deq_data_i(sb_deq_data_i), .sb_count_i(sb_count_i),
    .sb_flush_i(sb_flush_i), .sb_deq_req_o(sb_deq_req_o),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_addr_i(ld_req_addr_i),
    .ld_req_ready_o(ld_req_ready_o), .ld_resp_valid_o(ld_resp_valid_o),
    .ld_resp_data_o(ld_resp_data_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .drain_all_i(drain_all_i), .drain_done_o(drain_done_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // From a cycle where a load is being granted: issue, wait, respond, back to IDLE.
  task automatic finish_load(input logic [31:0] rdata);
    mem_req_ready_i = 1'b1;
    step();
    step();
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = rdata;
    step();
    mem_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    ld_req_valid_i = 1'b1;
    #2;
    checks++;
    if ({busy_o, mem_req_valid_o, mem_req_we_o, sb_deq_req_o, ld_req_ready_o,
         ld_resp_valid_o, drain_done_o} !== 7'b0)
      $display("FAIL reset_ctrl got %b required 0000000", {busy_o, mem_req_valid_o,
               mem_req_we_o, sb_deq_req_o, ld_req_ready_o, ld_resp_valid_o, drain_done_o});
    else passes++;
    checks++;
    if ({mem_req_addr_o, mem_req_wdata_o, ld_resp_data_o} !== 96'h0)
      $display("FAIL reset_data got %h required 0", {mem_req_addr_o, mem_req_wdata_o, ld_resp_data_o});
    else passes++;
    ld_req_valid_i = 1'b0;
    step();
    reset_ni = 1'b1;
    step();
  endtask

  task automatic test_idle_drain();
    sb_deq_valid_i = 1'b1; sb_deq_addr_i = 32'h100; sb_deq_data_i = 32'hAA; sb_count_i = 3'd1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || mem_req_valid_o !== 1'b0)
      $display("FAIL idle_grant_cycle busy=%b valid=%b required 0 0", busy_o, mem_req_valid_o);
    else passes++;
    step();
    checks++;
    if ({mem_req_valid_o, mem_req_we_o, busy_o} !== 3'b111 || mem_req_addr_o !== 32'h100 ||
        mem_req_wdata_o !== 32'hAA)
      $display("FAIL idle_issue v/we/busy=%b addr=%h wdata=%h required 111 100 aa",
               {mem_req_valid_o, mem_req_we_o, busy_o}, mem_req_addr_o, mem_req_wdata_o);
    else passes++;
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    #1;
    checks++;
    if (sb_deq_req_o !== 1'b0 || mem_req_valid_o !== 1'b0)
      $display("FAIL idle_wait_nopop pop=%b valid=%b required 0 0", sb_deq_req_o, mem_req_valid_o);
    else passes++;
    mem_resp_valid_i = 1'b1;
    #1;
    checks++;
    if (sb_deq_req_o !== 1'b1)
      $display("FAIL idle_pop got %b required 1", sb_deq_req_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b0; sb_deq_valid_i = 1'b0; sb_count_i = 3'd0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || sb_deq_req_o !== 1'b0)
      $display("FAIL idle_done busy=%b pop=%b required 0 0", busy_o, sb_deq_req_o);
    else passes++;
  endtask

  task automatic test_starvation();
    int grants = 0;
    sb_deq_valid_i = 1'b1; sb_deq_addr_i = 32'h300; sb_deq_data_i = 32'h33; sb_count_i = 3'd1;
    ld_req_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ld_req_addr_i = 32'h200 + 32'(i * 4);
      #1;
      if (ld_req_ready_o === 1'b1) grants++;
      mem_req_ready_i = 1'b1;
      step();
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b0 || mem_req_addr_o !== 32'h200 + 32'(i * 4))
        $display("FAIL starve_ld_issue%0d v=%b we=%b addr=%h required 1 0 %h", i, mem_req_valid_o,
                 mem_req_we_o, mem_req_addr_o, 32'h200 + 32'(i * 4));
      else passes++;
      step();
      mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'hD000 + 32'(i);
      #1;
      checks++;
      if (ld_resp_valid_o !== 1'b1 || ld_resp_data_o !== 32'hD000 + 32'(i))
        $display("FAIL starve_ld_resp%0d v=%b data=%h required 1 %h", i, ld_resp_valid_o,
                 ld_resp_data_o, 32'hD000 + 32'(i));
      else passes++;
      step();
      mem_resp_valid_i = 1'b0;
    end
    checks++;
    if (grants != 8) $display("FAIL starve_grants got %0d required 8", grants);
    else passes++;
    #1;
    checks++;
    if (ld_req_ready_o !== 1'b0) $display("FAIL starve_store_grant ready=%b required 0", ld_req_ready_o);
    else passes++;
    step();
    checks++;
    if (mem_req_we_o !== 1'b1 || mem_req_addr_o !== 32'h300 || mem_req_wdata_o !== 32'h33)
      $display("FAIL starve_store_issue we=%b addr=%h wdata=%h required 1 300 33", mem_req_we_o,
               mem_req_addr_o, mem_req_wdata_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b1;
    step();
    mem_resp_valid_i = 1'b0;
    sb_deq_addr_i = 32'h304; sb_deq_data_i = 32'h34;
    #1;
    checks++;
    if (ld_req_ready_o !== 1'b1)
      $display("FAIL starve_cnt_cleared ready=%b required 1", ld_req_ready_o);
    else passes++;
    finish_load(32'h0);
  endtask

  task automatic test_high_water();
    sb_count_i = 3'd3; sb_deq_addr_i = 32'h380; sb_deq_data_i = 32'h38;
    #1;
    checks++;
    if (ld_req_ready_o !== 1'b0) $display("FAIL hw_ready got %b required 0", ld_req_ready_o);
    else passes++;
    step();
    checks++;
    if (mem_req_we_o !== 1'b1 || mem_req_addr_o !== 32'h380)
      $display("FAIL hw_issue we=%b addr=%h required 1 380", mem_req_we_o, mem_req_addr_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b1;
    step();
    mem_resp_valid_i = 1'b0; sb_deq_valid_i = 1'b0; sb_count_i = 3'd0; ld_req_valid_i = 1'b0;
  endtask

  task automatic test_drain_all();
    int ld_grants = 0;
    int done_pulses = 0;
    drain_all_i = 1'b1; sb_deq_valid_i = 1'b1; sb_count_i = 3'd2;
    sb_deq_addr_i = 32'h400; sb_deq_data_i = 32'h44;
    #1;
    step();
    drain_all_i = 1'b0; ld_req_valid_i = 1'b1; ld_req_addr_i = 32'h480;
    #1;
    checks++;
    if (mem_req_we_o !== 1'b1 || mem_req_addr_o !== 32'h400)
      $display("FAIL drain_st0 we=%b addr=%h required 1 400", mem_req_we_o, mem_req_addr_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b1;
    step();
    mem_resp_valid_i = 1'b0; sb_count_i = 3'd1; sb_deq_addr_i = 32'h404; sb_deq_data_i = 32'h45;
    #1;
    if (ld_req_ready_o === 1'b1) ld_grants++;
    if (drain_done_o === 1'b1) done_pulses++;
    step();
    checks++;
    if (mem_req_we_o !== 1'b1 || mem_req_addr_o !== 32'h404 || mem_req_wdata_o !== 32'h45)
      $display("FAIL drain_st1 we=%b addr=%h wdata=%h required 1 404 45", mem_req_we_o,
               mem_req_addr_o, mem_req_wdata_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b1;
    step();
    mem_resp_valid_i = 1'b0; sb_deq_valid_i = 1'b0; sb_count_i = 3'd0;
    #1;
    if (ld_req_ready_o === 1'b1) ld_grants++;
    checks++;
    if (drain_done_o !== 1'b1) $display("FAIL drain_done got %b required 1", drain_done_o);
    else passes++;
    checks++;
    if (ld_grants != 0 || done_pulses != 0)
      $display("FAIL drain_no_loads grants=%0d early_done=%0d required 0 0", ld_grants, done_pulses);
    else passes++;
    step();
    checks++;
    if (drain_done_o !== 1'b0 || ld_req_ready_o !== 1'b1)
      $display("FAIL drain_resume done=%b ready=%b required 0 1", drain_done_o, ld_req_ready_o);
    else passes++;
    finish_load(32'h0);
    ld_req_valid_i = 1'b0;
  endtask

  task automatic test_back_pressure();
    int pops = 0;
    mem_req_ready_i = 1'b0;
    sb_deq_valid_i = 1'b1; sb_count_i = 3'd1; sb_deq_addr_i = 32'h500; sb_deq_data_i = 32'h55;
    #1;
    step();
    for (int i = 0; i < 5; i++) begin
      sb_deq_addr_i = 32'h5F0 + 32'(i); sb_deq_data_i = 32'h5F + 32'(i);
      #1;
      if (sb_deq_req_o === 1'b1) pops++;
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h500 || mem_req_wdata_o !== 32'h55)
        $display("FAIL bp_hold%0d v=%b addr=%h wdata=%h required 1 500 55", i, mem_req_valid_o,
                 mem_req_addr_o, mem_req_wdata_o);
      else passes++;
      step();
    end
    mem_req_ready_i = 1'b1;
    #1;
    step();
    #1;
    if (sb_deq_req_o === 1'b1) pops++;
    checks++;
    if (pops != 0) $display("FAIL bp_early_pop got %0d required 0", pops);
    else passes++;
    mem_resp_valid_i = 1'b1;
    #1;
    checks++;
    if (sb_deq_req_o !== 1'b1) $display("FAIL bp_pop got %b required 1", sb_deq_req_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b0; sb_deq_valid_i = 1'b0; sb_count_i = 3'd0;
  endtask

  task automatic test_flush_and_reset();
    sb_deq_valid_i = 1'b1; sb_count_i = 3'd1; sb_deq_addr_i = 32'h600; sb_deq_data_i = 32'h66;
    #1;
    step();
    step();
    sb_flush_i = 1'b1;
    #1;
    step();
    sb_flush_i = 1'b0; sb_deq_valid_i = 1'b0; sb_count_i = 3'd0; mem_resp_valid_i = 1'b1;
    #1;
    checks++;
    if (sb_deq_req_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL flush_nopop pop=%b busy=%b required 0 1", sb_deq_req_o, busy_o);
    else passes++;
    step();
    mem_resp_valid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL flush_idle busy=%b required 0", busy_o);
    else passes++;
    ld_req_valid_i = 1'b1; ld_req_addr_i = 32'h700;
    #1;
    step();
    step();
    mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'hBEEF;
    #1;
    reset_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, mem_req_valid_o, ld_resp_valid_o, ld_req_ready_o, sb_deq_req_o} !== 5'b0 ||
        ld_resp_data_o !== 32'h0 || mem_req_addr_o !== 32'h0)
      $display("FAIL reset_ldwait ctrl=%b data=%h addr=%h required 00000 0 0",
               {busy_o, mem_req_valid_o, ld_resp_valid_o, ld_req_ready_o, sb_deq_req_o},
               ld_resp_data_o, mem_req_addr_o);
    else passes++;
    ld_req_valid_i = 1'b0; mem_resp_valid_i = 1'b0;
    step();
    reset_ni = 1'b1;
    step();
    checks++;
    if (busy_o !== 1'b0 || mem_req_valid_o !== 1'b0)
      $display("FAIL reset_release busy=%b valid=%b required 0 0", busy_o, mem_req_valid_o);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_starvation();
    test_high_water();
    test_drain_all();
    test_back_pressure();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/store_drain_ctrl.md
Name: store_drain_ctrl

Overview:
- Controller between the store buffer dequeue port, the load unit and the single data-memory request port.
- Arbitrates the one memory port between load requests and store-buffer drains, and sequences each drain as issue -> wait-for-ack -> pop.
- Implements the drain policy: opportunistic drain, high-water drain, anti-starvation drain, and a fence-style drain-all.

Parameters:
ENTRY_COUNT, 4, store buffer depth; must match the attached store buffer.
HIGH_WATER, 3, sb_count at or above this value forces store priority.
STARVE_LIMIT, 8, consecutive load grants with a store pending before store priority is forced.
CNT_W, $clog2(ENTRY_COUNT+1), width of sb_count.

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset; asserted when 0
sb_deq_valid  in  1  store buffer head entry valid
sb_deq_addr  in  32  head entry address
sb_deq_data  in  32  head entry data
sb_count  in  CNT_W  store buffer occupancy
sb_flush  in  1  store buffer flush, same cycle as the buffer sees it
sb_deq_req  out  1  one-cycle pop pulse to the store buffer
ld_req_valid  in  1  load request
ld_req_addr  in  32  load address
ld_req_ready  out  1  load accepted this cycle
ld_resp_valid  out  1  load data valid
ld_resp_data  out  32  load data
mem_req_valid  out  1  memory request
mem_req_we  out  1  1 = store, 0 = load
mem_req_addr  out  32  memory address
mem_req_wdata  out  32  store data
mem_req_ready  in  1  memory accepts the request
mem_resp_valid  in  1  memory completion (write ack or read data)
mem_resp_rdata  in  32  read data
drain_all  in  1  pulse: drain the whole buffer (fence)
drain_done  out  1  one-cycle pulse: drain-all complete
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; starve_cnt=0; drain_mode=0; abandon=0; latched address/data = 0.
  - All outputs 0.
- FSM states: IDLE, ST_ISSUE, ST_WAIT, LD_ISSUE, LD_WAIT.
- Drain mode:
  - drain_all=1 sets drain_mode.
  - drain_done = drain_mode && IDLE && !sb_deq_valid, combinational pulse; drain_mode clears on the next edge.
  - drain_all while drain_mode is already set has no effect.
- IDLE store grant:
  - Condition: sb_deq_valid && (drain_mode || sb_count>=HIGH_WATER || starve_cnt>=STARVE_LIMIT || !ld_req_valid).
  - Latch sb_deq_addr/sb_deq_data; go to ST_ISSUE; clear starve_cnt.
- IDLE load grant:
  - Condition: otherwise, if ld_req_valid && !drain_mode.
  - ld_req_ready=1 combinationally this cycle; latch ld_req_addr; go to LD_ISSUE.
  - If sb_deq_valid, starve_cnt increments, saturating at STARVE_LIMIT.
- ld_req_ready is 0 in every state except IDLE with a load grant.
- ST_ISSUE / LD_ISSUE:
  - mem_req_valid=1 with latched address; mem_req_we=1 only in ST_ISSUE; wdata = latched data in ST_ISSUE, else 0.
  - Request is held stable until mem_req_ready=1, then go to ST_WAIT / LD_WAIT.
- Latency: grant at cycle t gives mem_req_valid at t+1.
- ST_WAIT, on mem_resp_valid:
  - sb_deq_req=1 for that cycle, unless abandon=1.
  - Go to IDLE; clear abandon.
  - The pop happens only after the memory ack, so store-to-load forwarding stays valid until memory holds the data.
- LD_WAIT, on mem_resp_valid:
  - ld_resp_valid=1 and ld_resp_data=mem_resp_rdata in the same cycle (combinational pass-through); go to IDLE.
- mem_resp_valid in any state other than *_WAIT is ignored. The memory guarantees the response comes at least one cycle after acceptance.
- sb_flush:
  - In ST_ISSUE or ST_WAIT: set abandon. The memory op still completes (a request is never withdrawn), but no pop is issued.
  - In IDLE: no effect beyond what sb_deq_valid shows.
  - Does not clear drain_mode.
- busy=1 in every state except IDLE.
- Reset asserted mid-transaction returns to IDLE at once; any in-flight memory op is dropped.
- Only one transaction is outstanding at a time; no pipelining.

Test Plan:
1. Idle drain: sb_count=1, head addr=0x100 data=0xAA, no loads. Expect mem_req_valid/we=1, addr=0x100, wdata=0xAA one cycle after grant. After mem_resp_valid: sb_deq_req pulses once, busy=0 the next cycle.
2. Load priority and starvation: sb_count=1, ld_req_valid held high, memory responds in 1 cycle. Expect 8 load grants, then a store grant on the next IDLE decision with starve_cnt reset to 0.
3. High-water: sb_count=3 with ld_req_valid=1. Expect a store grant and ld_req_ready=0 in that IDLE cycle.
4. Drain-all: sb_count=2, drain_all pulse, loads pending. Expect two stores with no load grants, then drain_done pulsing once, then load service resuming.
5. Back-pressure: mem_req_ready=0 for 5 cycles during ST_ISSUE. Expect mem_req_addr/wdata unchanged across all 5 cycles and no pop until the ack.
6. Flush mid-store: sb_flush in ST_WAIT, then mem_resp_valid. Expect no sb_deq_req, return to IDLE. Separately, reset=0 in LD_WAIT: all outputs 0 immediately.
